// File: rtl/tcdm_xbar_rr.sv
// TCDM crossbar: NumIn initiators onto NumOut word-interleaved banks, with
// round-robin arbitration per bank and fixed-latency response routing.
module tcdm_xbar_rr #(
    parameter int NumIn     = 4,
    parameter int NumOut    = 8,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int RespLat   = 1,
    localparam int BankSel       = (NumOut > 1) ? $clog2(NumOut) : 0,
    localparam int BeWidth       = DataWidth / 8,
    localparam int ByteOffWidth  = $clog2(BeWidth),
    localparam int BankAddrWidth = AddrWidth - ByteOffWidth - BankSel
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0][AddrWidth-1:0]      add_i,
    input  logic [NumIn-1:0]                     wen_i,
    input  logic [NumIn-1:0][DataWidth-1:0]      wdata_i,
    input  logic [NumIn-1:0][BeWidth-1:0]        be_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [NumIn-1:0][DataWidth-1:0]      rdata_o,
    output logic [NumOut-1:0]                    req_o,
    input  logic [NumOut-1:0]                    gnt_i,
    output logic [NumOut-1:0][BankAddrWidth-1:0] add_o,
    output logic [NumOut-1:0]                    wen_o,
    output logic [NumOut-1:0][DataWidth-1:0]     wdata_o,
    output logic [NumOut-1:0][BeWidth-1:0]       be_o,
    input  logic [NumOut-1:0][DataWidth-1:0]     rdata_i
);

    localparam int IdW   = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int BankW = (BankSel > 0) ? BankSel : 1;

    logic [NumOut-1:0][NumIn-1:0]             reqMask_s;
    logic [NumOut-1:0][IdW-1:0]               winner_s;
    logic [NumOut-1:0]                        hs_s;
    logic [NumOut-1:0][IdW-1:0]               rrPtr_r;
    logic [NumOut-1:0][IdW-1:0]               lockId_r;
    logic [NumOut-1:0]                        lock_r;
    logic [NumOut-1:0][RespLat-1:0]           pipeVld_r;
    logic [NumOut-1:0][RespLat-1:0][IdW-1:0]  pipeId_r;

    function automatic logic [BankW-1:0] bankOf(input logic [AddrWidth-1:0] addr);
        logic [AddrWidth-1:0] shifted;
        shifted = addr >> ByteOffWidth;
        return (BankSel == 0) ? '0 : shifted[BankW-1:0];
    endfunction

    // Sort requesting initiators by target bank.
    always_comb begin
        reqMask_s = '0;
        for (int b = 0; b < NumOut; b++) begin
            for (int i = 0; i < NumIn; i++) begin
                reqMask_s[b][i] = req_i[i] && (bankOf(add_i[i]) == BankW'(b));
            end
        end
    end

    // Per-bank winner: a stalled (locked) winner keeps the bank, otherwise round-robin from rrPtr.
    always_comb begin
        logic [IdW-1:0] rrWin;
        logic           found;
        logic           hit;
        logic           useLock;
        int             idx;
        winner_s = '0;
        rrWin    = '0;
        found    = 1'b0;
        hit      = 1'b0;
        useLock  = 1'b0;
        idx      = 0;
        for (int b = 0; b < NumOut; b++) begin
            rrWin = '0;
            found = 1'b0;
            for (int k = 0; k < NumIn; k++) begin
                idx   = int'(rrPtr_r[b]) + k;
                idx   = (idx >= NumIn) ? (idx - NumIn) : idx;
                hit   = !found && reqMask_s[b][idx];
                rrWin = hit ? IdW'(idx) : rrWin;
                found = found | hit;
            end
            useLock     = lock_r[b] && reqMask_s[b][lockId_r[b]];
            winner_s[b] = useLock ? lockId_r[b] : rrWin;
        end
    end

    // Bank-side request mux and initiator grants.
    always_comb begin
        req_o   = '0;
        hs_s    = '0;
        add_o   = '0;
        wen_o   = '0;
        wdata_o = '0;
        be_o    = '0;
        gnt_o   = '0;
        for (int b = 0; b < NumOut; b++) begin
            req_o[b]   = |reqMask_s[b];
            hs_s[b]    = req_o[b] & gnt_i[b];
            add_o[b]   = BankAddrWidth'(add_i[winner_s[b]] >> (ByteOffWidth + BankSel));
            wen_o[b]   = wen_i[winner_s[b]];
            wdata_o[b] = wdata_i[winner_s[b]];
            be_o[b]    = be_i[winner_s[b]];
            for (int i = 0; i < NumIn; i++) begin
                gnt_o[i] = gnt_o[i] | (hs_s[b] && (winner_s[b] == IdW'(i)));
            end
        end
    end

    // Route each bank's matured response slot back to its initiator.
    always_comb begin
        vld_o   = '0;
        rdata_o = '0;
        for (int b = 0; b < NumOut; b++) begin
            vld_o[pipeId_r[b][RespLat-1]]   = vld_o[pipeId_r[b][RespLat-1]] | pipeVld_r[b][RespLat-1];
            rdata_o[pipeId_r[b][RespLat-1]] = pipeVld_r[b][RespLat-1] ? rdata_i[b]
                                                                       : rdata_o[pipeId_r[b][RespLat-1]];
        end
    end

    // Round-robin pointer and stall lock per bank.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rrPtr_r  <= '0;
            lock_r   <= '0;
            lockId_r <= '0;
        end else begin
            for (int b = 0; b < NumOut; b++) begin
                if (hs_s[b]) begin
                    rrPtr_r[b] <= (winner_s[b] == IdW'(NumIn - 1)) ? '0 : winner_s[b] + IdW'(1);
                    lock_r[b]  <= 1'b0;
                end else begin
                    rrPtr_r[b] <= rrPtr_r[b];
                    lock_r[b]  <= req_o[b];
                end
                lockId_r[b] <= winner_s[b];
            end
        end
    end

    // Response shift registers: a slot enters every cycle, valid only on a handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipeVld_r <= '0;
            pipeId_r  <= '0;
        end else begin
            for (int b = 0; b < NumOut; b++) begin
                pipeVld_r[b][0] <= hs_s[b];
                pipeId_r[b][0]  <= winner_s[b];
                for (int s = 1; s < RespLat; s++) begin
                    pipeVld_r[b][s] <= pipeVld_r[b][s-1];
                    pipeId_r[b][s]  <= pipeId_r[b][s-1];
                end
            end
        end
    end

endmodule

// File: doc/tcdm_xbar_rr.md
TCDM_XBAR_RR -- requirements
Module: tcdm_xbar_rr

Interface
REQ-001 SHALL have parameter NumIn, default 4, meaning number of initiators (>=1).
REQ-002 SHALL have parameter NumOut, default 8, meaning number of banks (power of 2, >=1); BankSel = log2(NumOut), 0 when NumOut=1.
REQ-003 SHALL have parameter AddrWidth, default 32, meaning initiator byte-address width.
REQ-004 SHALL have parameter DataWidth, default 32, meaning word width; BeWidth = DataWidth/8, ByteOffWidth = log2(BeWidth).
REQ-005 SHALL have parameter RespLat, default 1, meaning bank read latency in cycles (1..4).
REQ-006 SHALL have ports clk_i in 1 (clock), then rst_i in 1; one clock, synchronous active-high reset.
REQ-007 SHALL have initiator ports req_i in [NumIn], add_i in [NumIn][AddrWidth], wen_i in [NumIn] (1=write), wdata_i in [NumIn][DataWidth], be_i in [NumIn][BeWidth].
REQ-008 SHALL have initiator outputs gnt_o out [NumIn], vld_o out [NumIn] (response valid), rdata_o out [NumIn][DataWidth].
REQ-009 SHALL have bank ports req_o out [NumOut], gnt_i in [NumOut], add_o out [NumOut][AddrWidth-ByteOffWidth-BankSel], wen_o out [NumOut], wdata_o out [NumOut][DataWidth], be_o out [NumOut][BeWidth], rdata_i in [NumOut][DataWidth].

Function
REQ-010 Target bank of initiator i SHALL be add_i[i][ByteOffWidth +: BankSel]; bank 0 when NumOut=1.
REQ-011 add_o[b] SHALL be winner's add_i >> (ByteOffWidth+BankSel); wen_o/wdata_o/be_o SHALL be winner's fields, combinationally.
REQ-012 req_o[b] SHALL be high iff at least one initiator with req_i high targets bank b.
REQ-013 Per bank, winner SHALL be first requesting initiator at or after rr_ptr[b], searching upward modulo NumIn.
REQ-014 Handshake on bank b = req_o[b] & gnt_i[b]; gnt_o[i] SHALL be high iff i is winner of its target bank and gnt_i of that bank is high.
REQ-015 On handshake, rr_ptr[b] SHALL become (winner+1) mod NumIn next cycle; otherwise held.
REQ-016 If req_o[b] high and gnt_i[b] low, bank b SHALL set lock[b] and keep the same winner next cycle regardless of rr_ptr; lock[b] clears on handshake or when locked initiator drops req_i.
REQ-017 Initiators SHALL hold req/add/wen/wdata/be stable until gnt_o; violation is a protocol error, no recovery required.
REQ-018 Each handshake SHALL push {valid, initiator id} into a per-bank RespLat-deep shift register; empty slots push valid=0.
REQ-019 vld_o[i] SHALL be high exactly RespLat cycles after a handshake by i, for reads and writes; rdata_o[i] = rdata_i[b] of that bank then, else 0.
REQ-020 At most one vld_o per initiator per cycle (one grant per initiator per cycle, fixed latency); SHALL hold by construction.
REQ-021 Back-to-back handshakes on one bank every cycle SHALL be sustained, full throughput, no bubble.
REQ-022 All NumOut banks SHALL arbitrate independently in the same cycle.
REQ-023 Handshake and response in same cycle on same bank SHALL both be processed (shift and push simultaneous).

Reset
REQ-024 While rst_i high at a clock edge: rr_ptr=0, lock=0, all shift-register valids=0.
REQ-025 Outputs after reset: vld_o=0, rdata_o=0; gnt_o/req_o follow combinational inputs.
REQ-026 Reset mid-operation SHALL discard in-flight responses; no vld_o for pre-reset handshakes.

Verification (NumIn=4, NumOut=4, DataWidth=32, RespLat=1)
REQ-027 Initiator 2 reads add 0x0000_0008 (bank 2), gnt_i=1 -> gnt_o[2]=1, add_o[2]=0, next cycle vld_o[2]=1, rdata_o[2]=rdata_i[2].
REQ-028 All 4 initiators read bank 0 continuously, gnt_i[0]=1 -> grants in order 0,1,2,3,0; vld_o one cycle after each.
REQ-029 Initiators 1,3 request bank 1, gnt_i[1]=0 for 3 cycles then 1 -> req_o[1]=1 throughout, winner stays 1, gnt_o[1] in 4th cycle, rr_ptr[1]=2.
REQ-030 Initiators 0..3 target banks 0..3 simultaneously -> all four gnt_o in one cycle, four vld_o next cycle.
REQ-031 Handshake at cycle N, rst_i high at N+1 (RespLat=2) -> no vld_o at N+2; rr_ptr all 0 afterward.
REQ-032 NumOut=1, NumIn=1 build: single initiator write -> gnt_o=gnt_i, vld_o RespLat cycles later.
